mean_unit: RTL and testbench
============================

Name: mean_unit

Overview:
- Stage-1 datapath engine of the linear-regression core.
- Launched by the controller's start1 pulse; its done output drives the controller's end1.
- Reads the 150 stored (x,y) samples from the sample register files, accumulates both sums, then divides each sum by 150 with a serial divider.
- Presents registered mean_x/mean_y to stages 2 and 3.

Parameters:
- WIDTH, 20, signed sample width of x and y.
- ACC_W, 28, accumulator width (WIDTH+8; holds 150 × max magnitude).
- ADDR_START, 8'd106, first sample address (controller's count reset value).
- ADDR_END, 8'd255, last sample address.
- N_SAMPLES, 150, divisor; equals ADDR_END-ADDR_START+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch pulse (controller start1).
- x_data  in  WIDTH  signed x sample at rd_addr; combinational read, valid same cycle.
- y_data  in  WIDTH  signed y sample at rd_addr; combinational read, valid same cycle.
- rd_addr  out  8  sample read address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse (to controller end1).
- mean_x  out  WIDTH  signed mean of x, registered.
- mean_y  out  WIDTH  signed mean of y, registered.

Behaviour:
- Reset (async, any state): state=IDLE, rd_addr=ADDR_START, sum_x=sum_y=0, mean_x=mean_y=0, done=0, busy=0, divider cleared.
- States: IDLE, ACCUM, DIVIDE, DONE.
- IDLE:
  - start=1 at edge k: clear sums, rd_addr=ADDR_START, go to ACCUM.
  - start=0: remain in IDLE; means hold their last values.
- ACCUM, one sample per cycle:
  - sum_x += sign-extended x_data; sum_y += sign-extended y_data.
  - rd_addr < ADDR_END: rd_addr increments.
  - rd_addr == ADDR_END: add the last sample, go to DIVIDE, load both dividers. rd_addr is not incremented past 255 and never wraps.
  - Exactly 150 accumulate edges, k+1 through k+150.
- DIVIDE:
  - Two serial_divider instances run in parallel, ACC_W steps (edges k+151 through k+178).
  - Each divides the magnitude of its sum by N_SAMPLES, restoring algorithm, one quotient bit per cycle.
  - Quotient is negated if the sum was negative: truncation toward zero.
  - At the final step, mean_x/mean_y load the low WIDTH bits of their quotients and the state goes to DONE.
- DONE: done=1 for exactly the cycle following edge k+178; next edge returns to IDLE. Total start-to-done latency is 178 edges.
- start while busy=1 is ignored: no restart, no queuing.
- start arriving on the same edge DONE→IDLE is ignored; the controller only issues start1 from IDLE anyway.
- Reset mid-ACCUM or mid-DIVIDE aborts the operation, zeroes the means, and produces no done pulse.
- Width rule: |mean| ≤ max |sample|, so truncation to WIDTH is lossless. No saturation logic.

Decomposition:
- Shared package/header: state encodings, ADDR_START, ADDR_END, N_SAMPLES, WIDTH, ACC_W. The controller uses the same address constants.
- Sub-module serial_divider:
  - Parameters: width, divisor.
  - Interface: load, dividend, busy/valid, quotient.
  - Instantiated twice, for x and y.

Test Plan:
- All x=1, y=2; single start pulse → done exactly 178 edges later, mean_x=1, mean_y=2, busy high throughout, rd_addr sweeps 106..255.
- x[a]=a-106 (values 0..149), y[a]=-(a-106) → sum 11175 / 150 → mean_x=74, mean_y=-74 (truncation toward zero).
- Alternating x=-1,0 starting at address 106 → sum -75 → mean_x=0; all y=-3 → mean_y=-3.
- All samples = 2^19-1 and separately -2^19 → means equal those values exactly; no overflow.
- start re-pulsed during ACCUM and during DIVIDE → ignored, single done at edge 178, correct means.
- reset asserted mid-ACCUM (address ~180) → immediate IDLE, means=0, no done; a new start then completes normally.

Source files
------------

// File: rtl/mean_unit_pkg.sv
// Shared constants and types for the stage-1 mean engine of the linear-regression core.
// The controller uses the same sample address window.
package mean_unit_pkg;

    localparam int WIDTH     = 20;
    localparam int ACC_W     = 28;
    localparam int N_SAMPLES = 150;

    localparam logic [7:0] ADDR_START = 8'd106;
    localparam logic [7:0] ADDR_END   = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic signed [ACC_W-1:0] sext_sample(input logic signed [WIDTH-1:0] s);
        return {{(ACC_W-WIDTH){s[WIDTH-1]}}, s};
    endfunction

endpackage

// File: rtl/mean_unit_serial_divider.sv
// Restoring serial divider by a constant: one quotient bit per cycle, signed result
// truncated toward zero. valid flags the cycle whose edge completes the division.
module serial_divider #(
    parameter int WIDTH     = 28,
    parameter int DIVISOR   = 150,
    parameter int OUT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     dividend,
    output logic                 busy,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] quotient
);

    localparam int RW = $clog2(DIVISOR) + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [RW-1:0] DIV_C = RW'(DIVISOR);

    logic              busy_q, busy_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [RW-2:0]     rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [RW-1:0]     rem_shift_s;
    logic [RW-2:0]     rem_sub_s;
    logic              ge_s;
    logic [WIDTH-1:0]  work_next_s;
    logic              last_s;
    logic [OUT_WIDTH-1:0] quot_mag_s;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_shift_s = {rem_q, work_q[WIDTH-1]};
        ge_s        = (rem_shift_s >= DIV_C);
        rem_sub_s   = rem_shift_s[RW-2:0] - DIV_C[RW-2:0];
        work_next_s = {work_q[WIDTH-2:0], ge_s};
        last_s      = busy_q && (cnt_q == CW'(WIDTH - 1));
        quot_mag_s  = work_next_s[OUT_WIDTH-1:0];
    end

    // Load / step control for the divider registers.
    always_comb begin
        busy_d = busy_q;
        neg_d  = neg_q;
        work_d = work_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        if (load) begin
            busy_d = 1'b1;
            neg_d  = dividend[WIDTH-1];
            work_d = dividend[WIDTH-1] ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
            rem_d  = '0;
            cnt_d  = '0;
        end else if (busy_q) begin
            work_d = work_next_s;
            rem_d  = ge_s ? rem_sub_s : rem_shift_s[RW-2:0];
            cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            work_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            neg_q  <= neg_d;
            work_q <= work_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = last_s;
    assign quotient = neg_q ? (~quot_mag_s + {{(OUT_WIDTH-1){1'b0}}, 1'b1}) : quot_mag_s;

endmodule

// File: rtl/mean_unit.sv
// Stage-1 engine: sums the 150 stored (x,y) samples, then divides both sums by 150
// in parallel serial dividers and presents registered means.
module mean_unit
    import mean_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_data,
    input  logic [WIDTH-1:0] y_data,
    output logic [7:0]       rd_addr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mean_x,
    output logic [WIDTH-1:0] mean_y
);

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [ACC_W-1:0]  sum_x_q, sum_x_d;
    logic [ACC_W-1:0]  sum_y_q, sum_y_d;
    logic [WIDTH-1:0]  mean_x_q, mean_x_d;
    logic [WIDTH-1:0]  mean_y_q, mean_y_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              div_load_s;
    logic              dx_busy_s, dy_busy_s;
    logic              dx_valid_s, dy_valid_s;
    logic [WIDTH-1:0]  qx_s, qy_s;
    logic              div_fin_s;

    assign div_fin_s = dx_valid_s & dy_valid_s & dx_busy_s & dy_busy_s;

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        mean_x_d   = mean_x_q;
        mean_y_d   = mean_y_q;
        div_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_x_d = '0;
                    sum_y_d = '0;
                    addr_d  = ADDR_START;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                sum_x_d = sum_x_q + sext_sample(x_data);
                sum_y_d = sum_y_q + sext_sample(y_data);
                // The final sample is folded into the divider load, so the address parks at the end.
                if (addr_q == ADDR_END) begin
                    div_load_s = 1'b1;
                    state_d    = ST_DIVIDE;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end
            ST_DIVIDE: begin
                if (div_fin_s) begin
                    mean_x_d = qx_s;
                    mean_y_d = qy_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Engine state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= ADDR_START;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            mean_x_q <= '0;
            mean_y_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            mean_x_q <= mean_x_d;
            mean_y_q <= mean_y_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    serial_divider #(
        .WIDTH    (ACC_W),
        .DIVISOR  (N_SAMPLES),
        .OUT_WIDTH(WIDTH)
    ) u_div_x (
        .clk     (clk),
        .reset   (reset),
        .load    (div_load_s),
        .dividend(sum_x_d),
        .busy    (dx_busy_s),
        .valid   (dx_valid_s),
        .quotient(qx_s)
    );

    serial_divider #(
        .WIDTH    (ACC_W),
        .DIVISOR  (N_SAMPLES),
        .OUT_WIDTH(WIDTH)
    ) u_div_y (
        .clk     (clk),
        .reset   (reset),
        .load    (div_load_s),
        .dividend(sum_y_d),
        .busy    (dy_busy_s),
        .valid   (dy_valid_s),
        .quotient(qy_s)
    );

    assign rd_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mean_x  = mean_x_q;
    assign mean_y  = mean_y_q;

endmodule

// File: tb/tb_mean_unit.sv
// Self-checking bench for mean_unit: sample memories, expected-mean scoreboard, latency/sweep checks.
module tb_mean_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] x_data;
    logic [19:0] y_data;
    logic [7:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [19:0] mean_x;
    logic [19:0] mean_y;

    logic signed [19:0] xmem [0:255];
    logic signed [19:0] ymem [0:255];

    int errors = 0;
    int checks = 0;

    logic signed [19:0] exp_x_q [$];
    logic signed [19:0] exp_y_q [$];

    mean_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x_data (x_data),
        .y_data (y_data),
        .rd_addr(rd_addr),
        .busy   (busy),
        .done   (done),
        .mean_x (mean_x),
        .mean_y (mean_y)
    );

    assign x_data = xmem[rd_addr];
    assign y_data = ymem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill(input int mode);
        for (int a = 0; a < 256; a++) begin
            int r;
            r = a - 106;
            case (mode)
                0: begin xmem[a] = 20'sd1; ymem[a] = 20'sd2; end
                1: begin xmem[a] = 20'(r); ymem[a] = 20'(-r); end
                2: begin xmem[a] = (a % 2 == 0) ? -20'sd1 : 20'sd0; ymem[a] = -20'sd3; end
                3: begin xmem[a] = 20'sd524287; ymem[a] = 20'sd524287; end
                4: begin xmem[a] = 20'h80000; ymem[a] = 20'h80000; end
                default: begin xmem[a] = 20'sd0; ymem[a] = 20'sd0; end
            endcase
        end
    endtask

    task automatic push_expected();
        int sx, sy;
        sx = 0;
        sy = 0;
        for (int a = 106; a < 256; a++) begin
            sx += int'(xmem[a]);
            sy += int'(ymem[a]);
        end
        exp_x_q.push_back(20'(sx / 150));
        exp_y_q.push_back(20'(sy / 150));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input bit repulse);
        int lat;
        int addr_bad;
        int busy_bad;
        logic signed [19:0] ex, ey;
        push_expected();
        pulse_start();
        checks++;
        if (rd_addr !== 8'd106 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s launch: rd_addr=%0d busy=%b, want 106/1", name, rd_addr, busy);
        end
        lat = 0;
        addr_bad = 0;
        busy_bad = 0;
        for (int n = 1; n <= 400; n++) begin
            if (repulse && (n == 50 || n == 160)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (rd_addr !== ((n < 150) ? 8'(106 + n) : 8'd255)) addr_bad++;
        end
        checks++;
        if (lat != 178) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want 178", name, lat);
        end
        checks++;
        if (addr_bad != 0 || busy_bad != 0) begin
            errors++;
            $display("FAIL %s sweep: addr_errs=%0d busy_errs=%0d, want 0/0", name, addr_bad, busy_bad);
        end
        ex = exp_x_q.pop_front();
        ey = exp_y_q.pop_front();
        checks++;
        if (mean_x !== ex) begin
            errors++;
            $display("FAIL %s mean_x: got %0d, want %0d", name, $signed(mean_x), ex);
        end
        checks++;
        if (mean_y !== ey) begin
            errors++;
            $display("FAIL %s mean_y: got %0d, want %0d", name, $signed(mean_y), ey);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || mean_x !== ex) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b mean_x=%0d, want 0/0/%0d",
                     name, done, busy, $signed(mean_x), ex);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (rd_addr !== 8'd106 || busy !== 1'b0 || done !== 1'b0 ||
            mean_x !== 20'd0 || mean_y !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: rd_addr=%0d busy=%b done=%b mx=%0d my=%0d, want 106/0/0/0/0",
                     rd_addr, busy, done, mean_x, mean_y);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        fill(1);
        push_expected();
        pulse_start();
        for (int n = 1; n <= 74; n++) @(posedge clk);
        #1;
        checks++;
        if (rd_addr !== 8'd180) begin
            errors++;
            $display("FAIL abort_point: rd_addr=%0d, want 180", rd_addr);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || mean_x !== 20'd0 || mean_y !== 20'd0 || rd_addr !== 8'd106) begin
            errors++;
            $display("FAIL abort_reset: busy=%b mx=%0d my=%0d rd_addr=%0d, want 0/0/0/106",
                     busy, mean_x, mean_y, rd_addr);
        end
        #1;
        reset = 1'b0;
        void'(exp_x_q.pop_front());
        void'(exp_y_q.pop_front());
        seen_done = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: activity cycles=%0d, want 0", seen_done);
        end
        run_op("after_abort", 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(0);
        test_reset();
        fill(0); run_op("const_1_2", 1'b0);
        fill(1); run_op("ramp", 1'b0);
        fill(2); run_op("alternating", 1'b0);
        fill(3); run_op("max_pos", 1'b0);
        fill(4); run_op("max_neg", 1'b0);
        fill(1); run_op("back_to_back_repulse", 1'b1);
        test_reset_abort();
        checks++;
        if (exp_x_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_x_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
